// File: rtl/jtframe_gfx_pkg.sv
// Shared definitions for the object drawing blocks.
//   obj_state_t : encoding of the object draw FSM (IDLE / FETCH / DRAW)
//   obj_plane() : extracts one 8-pixel bit plane from a 32-bit ROM word
package jtframe_gfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAW  = 2'd2
  } obj_state_t;

  // Plane p (0..3) is built from two nibbles of the ROM word: nibble p of
  // the low half gives bits [3:0] and nibble p of the high half gives bits
  // [7:4]. Bit j of the plane belongs to pixel column j.
  function automatic logic [7:0] obj_plane(input logic [31:0] d, input int p);
    obj_plane = {d[16+4*p +: 4], d[4*p +: 4]};
  endfunction

endpackage

// File: rtl/jtframe_obj_unpack.sv
// Combinational unpack of one 32-bit object ROM word into eight 4-bit pixels.
//   data   : ROM word, four interleaved bit planes
//   hflip  : mirror the row (pixel k takes column 7-k)
//   pixels : pixels[k] is the pen for output position k, plane 0 as MSB
module jtframe_obj_unpack
  import jtframe_gfx_pkg::*;
(
  input  logic [31:0]     data,
  input  logic            hflip,
  output logic [7:0][3:0] pixels
);

  logic [7:0] p0, p1, p2, p3;

  assign p0 = obj_plane(data, 0);
  assign p1 = obj_plane(data, 1);
  assign p2 = obj_plane(data, 2);
  assign p3 = obj_plane(data, 3);

  always_comb begin
    pixels = '0;
    for (int k = 0; k < 8; k++) begin
      pixels[k] = hflip ? {p0[7-k], p1[7-k], p2[7-k], p3[7-k]}
                        : {p0[k],   p1[k],   p2[k],   p3[k]};
    end
  end

endmodule

// File: rtl/jtframe_obj_draw.sv
// Object line drawer: fetches one row of an 8- or 16-pixel-wide object from
// ROM and writes its pixels into an external line buffer.
//   LHBL, start, code, xpos, ysub, pal, hflip, vflip : draw request inputs
//   busy, done                 : request status, done is a 1-cycle pulse
//   rom_addr, rom_cs, rom_ok, rom_data : ROM word port
//   buf_addr, buf_din, buf_we  : line buffer write port
//
// ROM handshake: rom_cs is held high for the whole FETCH state together with
// a stable rom_addr. rom_ok is not looked at on the first FETCH cycle (it may
// still belong to an older request); the first rom_ok=1 after that is the
// data strobe: rom_data is captured on that edge and rom_cs drops next cycle.
module jtframe_obj_draw
  import jtframe_gfx_pkg::*;
#(
  parameter int          CW        = 10,
  parameter int          PALW      = 4,
  parameter int          AW        = 9,
  parameter int          SIZE16    = 0,
  parameter logic [3:0]  TRANSP    = 4'hF,
  parameter int          TRANSP_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 LHBL,
  input  logic                 start,
  input  logic [CW-1:0]        code,
  input  logic [AW-1:0]        xpos,
  input  logic [2:0]           ysub,
  input  logic [PALW-1:0]      pal,
  input  logic                 hflip,
  input  logic                 vflip,
  output logic                 busy,
  output logic                 done,
  output logic [CW+SIZE16+2:0] rom_addr,
  output logic                 rom_cs,
  input  logic                 rom_ok,
  input  logic [31:0]          rom_data,
  output logic [AW-1:0]        buf_addr,
  output logic [PALW+3:0]      buf_din,
  output logic                 buf_we
);

  obj_state_t state, state_nx;

  logic [CW-1:0]        code_r;
  logic [AW-1:0]        xpos_r;
  logic [2:0]           ysub_r;
  logic [PALW-1:0]      pal_r;
  logic                 hflip_r, vflip_r;
  logic                 h;            // which 8-pixel half is being drawn
  logic                 fetch_first;  // high on the first cycle of FETCH
  logic [2:0]           cnt;
  logic [31:0]          data_r;
  logic                 done_r;
  logic [7:0][3:0]      pixels;
  logic [3:0]           pix;
  logic [2:0]           row;
  logic [CW+SIZE16+2:0] fetch_addr;

  logic accept, take, last, more;

  assign accept = (state == ST_IDLE)  && LHBL && start;
  assign take   = (state == ST_FETCH) && LHBL && !fetch_first && rom_ok;
  assign last   = (state == ST_DRAW)  && LHBL && (cnt == 3'd7);
  assign more   = last && (SIZE16 != 0) && !h;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a low LHBL overrides everything
  always_comb begin
    state_nx = state;
    if (!LHBL) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_nx = ST_FETCH;
        ST_FETCH: if (take)   state_nx = ST_DRAW;
        ST_DRAW:  if (last)   state_nx = more ? ST_FETCH : ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Request latch, ROM word capture and pixel counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_r      <= '0;
      xpos_r      <= '0;
      ysub_r      <= '0;
      pal_r       <= '0;
      hflip_r     <= 1'b0;
      vflip_r     <= 1'b0;
      h           <= 1'b0;
      fetch_first <= 1'b0;
      cnt         <= '0;
      data_r      <= '0;
      done_r      <= 1'b0;
    end else begin
      fetch_first <= accept || more;
      done_r      <= last && !more;
      if (accept) begin
        code_r  <= code;
        xpos_r  <= xpos;
        ysub_r  <= ysub;
        pal_r   <= pal;
        hflip_r <= hflip;
        vflip_r <= vflip;
        h       <= 1'b0;
      end
      if (more) h <= 1'b1;
      if (take) begin
        data_r <= rom_data;
        cnt    <= '0;
      end else if (state == ST_DRAW) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  jtframe_obj_unpack u_unpack (
    .data   (data_r),
    .hflip  (hflip_r),
    .pixels (pixels)
  );

  assign pix = pixels[cnt];
  assign row = ysub_r ^ {3{vflip_r}};

  // The half bit selects the left or right 8 pixels of a 16-wide object;
  // with hflip the right half is fetched first.
  if (SIZE16 != 0) begin : g_half
    assign fetch_addr = {code_r, hflip_r ^ h, row};
  end else begin : g_nohalf
    assign fetch_addr = {code_r, row};
  end

  // Output logic
  always_comb begin
    busy     = (state != ST_IDLE);
    done     = done_r;
    rom_cs   = (state == ST_FETCH);
    rom_addr = '0;
    buf_addr = '0;
    buf_din  = '0;
    buf_we   = 1'b0;
    if (state == ST_FETCH) rom_addr = fetch_addr;
    if (state == ST_DRAW) begin
      // address wraps silently at the buffer size
      buf_addr = xpos_r + AW'({h, cnt});
      buf_din  = {pal_r, pix};
      buf_we   = !((TRANSP_EN != 0) && (pix == TRANSP));
    end
  end

endmodule

// File: tb/tb_jtframe_obj_draw.sv
// Directed bench for jtframe_obj_draw: one 8-wide instance (defaults) and
// one 16-wide instance sharing every input except start.
module tb_jtframe_obj_draw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, LHBL, start8, start16;
  logic [9:0]  code;
  logic [8:0]  xpos;
  logic [2:0]  ysub;
  logic [3:0]  pal;
  logic        hflip, vflip, rom_ok;
  logic [31:0] rom_data;

  logic        busy8, done8, rom_cs8, buf_we8;
  logic [12:0] rom_addr8;
  logic [8:0]  buf_addr8;
  logic [7:0]  buf_din8;

  logic        busy16, done16, rom_cs16, buf_we16;
  logic [13:0] rom_addr16;
  logic [8:0]  buf_addr16;
  logic [7:0]  buf_din16;

  jtframe_obj_draw u_dut8 (
    .clk(clk), .rst_n(rst_n), .LHBL(LHBL), .start(start8), .code(code),
    .xpos(xpos), .ysub(ysub), .pal(pal), .hflip(hflip), .vflip(vflip),
    .busy(busy8), .done(done8), .rom_addr(rom_addr8), .rom_cs(rom_cs8),
    .rom_ok(rom_ok), .rom_data(rom_data), .buf_addr(buf_addr8),
    .buf_din(buf_din8), .buf_we(buf_we8)
  );

  jtframe_obj_draw #(.SIZE16(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .LHBL(LHBL), .start(start16), .code(code),
    .xpos(xpos), .ysub(ysub), .pal(pal), .hflip(hflip), .vflip(vflip),
    .busy(busy16), .done(done16), .rom_addr(rom_addr16), .rom_cs(rom_cs16),
    .rom_ok(rom_ok), .rom_data(rom_data), .buf_addr(buf_addr16),
    .buf_din(buf_din16), .buf_we(buf_we16)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [16:0] exp_q[$];   // expected writes {addr, din}
  logic [16:0] mon_got, mon_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every buffer write must match the head of the queue
  always @(negedge clk) begin
    if (done8 || done16) done_cnt++;
    if (buf_we8 || buf_we16) begin
      mon_got = buf_we16 ? {buf_addr16, buf_din16} : {buf_addr8, buf_din8};
      if (exp_q.size() == 0) begin
        check_val("write_unexpected", {15'd0, mon_got}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check_val("write", {15'd0, mon_got}, {15'd0, mon_exp});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic set_req(input logic [9:0] c, input logic [8:0] x, input logic [2:0] ys,
                         input logic [3:0] p, input logic hf, input logic vf);
    code = c; xpos = x; ysub = ys; pal = p; hflip = hf; vflip = vf;
  endtask

  // Raise start now; it is sampled on the next rising edge
  task automatic issue(input bit sel);
    if (sel) start16 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
  endtask

  // Expected row: pixel k pen in bits [4k+3:4k]; pen F is never written
  task automatic push_row(input logic [8:0] x0, input logic [3:0] p, input logic [31:0] row);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] px;
      px = row[4*k +: 4];
      if (px != 4'hF) exp_q.push_back({9'(x0 + 9'(k)), p, px});
    end
  endtask

  // Wait for rom_cs, check address, answer rom_ok three cycles after rom_cs rose
  task automatic serve(input bit sel, input logic [13:0] exp_addr, input logic [31:0] d,
                       input string tag);
    int n = 0;
    while (!(sel ? rom_cs16 : rom_cs8) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_cs"}, {31'd0, sel ? rom_cs16 : rom_cs8}, 32'd1);
    check_val({tag, "_addr"}, {18'd0, sel ? rom_addr16 : {1'b0, rom_addr8}}, {18'd0, exp_addr});
    repeat (2) @(posedge clk);
    #1 rom_ok = 1'b1; rom_data = d;
    @(posedge clk);
    #1 rom_ok = 1'b0; rom_data = 32'h0;
  endtask

  // Count clock cycles from data capture to done
  task automatic wait_done(input bit sel, input int exp_lat, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(sel ? done16 : done8) && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_val({tag, "_lat"}, n, exp_lat);
    check_val({tag, "_busy_at_done"}, {31'd0, sel ? busy16 : busy8}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; LHBL = 1'b1; start8 = 1'b0; start16 = 1'b0;
    rom_ok = 1'b0; rom_data = 32'h0;
    set_req(10'h0, 9'h0, 3'd0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_val("rst_ctrl", {28'd0, busy8, done8, rom_cs8, buf_we8}, 32'd0);
    check_val("rst_rom_addr", {19'd0, rom_addr8}, 32'd0);
    check_val("rst_buf", {15'd0, buf_addr8, buf_din8}, 32'd0);
    check_val("rst_ctrl16", {28'd0, busy16, done16, rom_cs16, buf_we16}, 32'd0);

    // t1: request on the first edge after reset release, all pixels 0xE
    rst_n = 1'b1;
    set_req(10'h155, 9'h010, 3'd2, 4'h5, 1'b0, 1'b0);
    issue(0);
    check_val("t1_busy", {31'd0, busy8}, 32'd1);
    push_row(9'h010, 4'h5, 32'hEEEE_EEEE);
    serve(0, 14'h0AAA, 32'h0FFF_0FFF, "t1");
    wait_done(0, 8, "t1");

    // t2: back-to-back on the done cycle, vflip, data 0xFF
    set_req(10'h02A, 9'h100, 3'd5, 4'h3, 1'b0, 1'b1);
    issue(0);
    check_val("t2_done_one_cycle", {31'd0, done8}, 32'd0);
    check_val("t2_busy", {31'd0, busy8}, 32'd1);
    push_row(9'h100, 4'h3, 32'h0000_CCCC);
    serve(0, 14'h0152, 32'h0000_00FF, "t2");
    wait_done(0, 8, "t2");

    // t3: hflip, single P0 bit lands at xpos+3
    @(negedge clk);
    set_req(10'h155, 9'h020, 3'd2, 4'h7, 1'b1, 1'b0);
    issue(0);
    push_row(9'h020, 4'h7, 32'h0000_8000);
    serve(0, 14'h0AAA, 32'h0001_0000, "t3");
    wait_done(0, 8, "t3");
    check_val("t3_q_empty", exp_q.size(), 0);

    // t4: start with LHBL low ignored; start while busy ignored; all transparent
    @(negedge clk);
    LHBL = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; LHBL = 1'b1;
    check_val("lhbl_low_start", {31'd0, busy8}, 32'd0);
    set_req(10'h3C1, 9'h1F0, 3'd7, 4'hA, 1'b0, 1'b0);
    issue(0);
    set_req(10'h000, 9'h000, 3'd0, 4'h0, 1'b1, 1'b1);
    start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    @(negedge clk);
    check_val("busy_start_ignored", {19'd0, rom_addr8}, 32'h1E0F);
    serve(0, 14'h1E0F, 32'hFFFF_FFFF, "t4");
    wait_done(0, 8, "t4");

    // t5: 16-wide, hflip, address wrap, one done pulse
    @(negedge clk);
    set_req(10'h155, 9'h1FC, 3'd2, 4'h9, 1'b1, 1'b0);
    done_cnt = 0;
    issue(1);
    push_row(9'h1FC, 4'h9, 32'h0);
    push_row(9'h004, 4'h9, 32'h0);
    serve(1, 14'h155A, 32'h0, "t5a");
    serve(1, 14'h1552, 32'h0, "t5b");
    wait_done(1, 8, "t5");
    repeat (3) @(negedge clk);
    check_val("t5_done_count", done_cnt, 1);
    check_val("t5_q_empty", exp_q.size(), 0);

    // t6: LHBL dropped on DRAW cycle 3
    set_req(10'h011, 9'h040, 3'd0, 4'h1, 1'b0, 1'b0);
    done_cnt = 0;
    issue(0);
    push_row(9'h040, 4'h1, 32'hFFFF_EEEE);
    serve(0, 14'h0088, 32'h0FFF_0FFF, "t6");
    repeat (3) @(posedge clk);
    #1 LHBL = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("abort_we", {31'd0, buf_we8}, 32'd0);
    check_val("abort_busy", {31'd0, busy8}, 32'd0);
    check_val("abort_done", {31'd0, done8}, 32'd0);
    LHBL = 1'b1;
    rom_ok = 1'b1; rom_data = 32'h1234_5678;
    @(negedge clk);
    rom_ok = 1'b0; rom_data = 32'h0;
    check_val("abort_rom_ok_busy", {31'd0, busy8}, 32'd0);
    check_val("abort_rom_ok_cs", {31'd0, rom_cs8}, 32'd0);
    repeat (10) @(negedge clk);
    check_val("abort_no_done", done_cnt, 0);
    check_val("abort_q_empty", exp_q.size(), 0);

    // t7: reset mid-FETCH, then a start on the first edge after release
    set_req(10'h2F0, 9'h0F8, 3'd1, 4'hC, 1'b0, 1'b1);
    issue(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_ctrl", {28'd0, busy8, done8, rom_cs8, buf_we8}, 32'd0);
    check_val("rst_mid_rom_addr", {19'd0, rom_addr8}, 32'd0);
    check_val("rst_mid_buf", {15'd0, buf_addr8, buf_din8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0);
    check_val("t7_busy", {31'd0, busy8}, 32'd1);
    push_row(9'h0F8, 4'hC, 32'h0000_CCCC);
    serve(0, 14'h1786, 32'h0000_00FF, "t7");
    wait_done(0, 8, "t7");
    check_val("t7_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
